// File: rtl/test_pattern_gen_pkg.sv
// ============================================================================
// Module      : test_pattern_pkg
// Description : Shared types, colour constants and bar lookup for the
//               240p test pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package test_pattern_pkg;

    typedef enum logic [2:0] {
        PAT_BLACK   = 3'd0,
        PAT_BARS    = 3'd1,
        PAT_GRID    = 3'd2,
        PAT_CHECKER = 3'd3,
        PAT_RAMP    = 3'd4,
        PAT_MOVE    = 3'd5
    } pattern_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t C_WHITE   = 24'hFF_FF_FF;
    localparam rgb_t C_YELLOW  = 24'hFF_FF_00;
    localparam rgb_t C_CYAN    = 24'h00_FF_FF;
    localparam rgb_t C_GREEN   = 24'h00_FF_00;
    localparam rgb_t C_MAGENTA = 24'hFF_00_FF;
    localparam rgb_t C_RED     = 24'hFF_00_00;
    localparam rgb_t C_BLUE    = 24'h00_00_FF;
    localparam rgb_t C_BLACK   = 24'h00_00_00;

    // Classic 75%-style order, left to right, at full amplitude.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = C_WHITE;
            3'd1:    c = C_YELLOW;
            3'd2:    c = C_CYAN;
            3'd3:    c = C_GREEN;
            3'd4:    c = C_MAGENTA;
            3'd5:    c = C_RED;
            3'd6:    c = C_BLUE;
            default: c = C_BLACK;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/test_pattern_gen_frame_ctrl.sv
// ============================================================================
// Module      : pattern_frame_ctrl
// Description : Frame boundary detection, frame counter, pattern latch and
//               moving-bar position.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_frame_ctrl #(
    parameter int H_ACTIVE  = 320,
    parameter int MOVE_STEP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       v_blank_in,
    input  logic [2:0] pattern_sel,
    output logic [7:0] frame_count,
    output logic [2:0] pattern_active,
    output logic [9:0] move_pos
);

    logic       r_vb_prev;
    logic [7:0] r_frame_count;
    logic [2:0] r_pattern;
    logic [9:0] r_move_pos;

    logic       w_boundary;
    logic [9:0] w_pos_sum;
    logic [9:0] w_pos_next;

    assign w_boundary = v_blank_in & ~r_vb_prev;
    assign w_pos_sum  = r_move_pos + 10'(MOVE_STEP);
    assign w_pos_next = (w_pos_sum >= 10'(H_ACTIVE)) ? 10'd0 : w_pos_sum;

    // Previous v_blank resets high so release during blanking is not a boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vb_prev     <= 1'b1;
            r_frame_count <= 8'd0;
            r_pattern     <= 3'd0;
            r_move_pos    <= 10'd0;
        end else if (ce_pix) begin
            r_vb_prev <= v_blank_in;
            if (w_boundary) begin
                r_frame_count <= r_frame_count + 8'd1;
                r_pattern     <= pattern_sel;
                r_move_pos    <= w_pos_next;
            end
        end
    end

    assign frame_count    = r_frame_count;
    assign pattern_active = r_pattern;
    assign move_pos       = r_move_pos;

endmodule

`default_nettype wire

// File: rtl/test_pattern_gen.sv
// ============================================================================
// Module      : test_pattern_gen
// Description : Two-stage 240p test pattern generator with delay-matched
//               timing outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module test_pattern_gen #(
    parameter int H_ACTIVE  = 320,
    parameter int V_ACTIVE  = 240,
    parameter int BAR_W     = 40,
    parameter int GRID_STEP = 16,
    parameter int MOVE_W    = 8,
    parameter int MOVE_STEP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       de_in,
    input  logic       h_blank_in,
    input  logic       v_blank_in,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic [2:0] pattern_sel,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       de_out,
    output logic       h_blank_out,
    output logic       v_blank_out,
    output logic       h_sync_out,
    output logic       v_sync_out,
    output logic [2:0] pattern_active,
    output logic [7:0] frame_count
);

    import test_pattern_pkg::*;

    localparam int C_BAR_CW = $clog2(BAR_W);

    logic [9:0] w_move_pos;

    pattern_frame_ctrl #(
        .H_ACTIVE  (H_ACTIVE),
        .MOVE_STEP (MOVE_STEP)
    ) u_frame_ctrl (
        .clk            (clk),
        .reset          (reset),
        .ce_pix         (ce_pix),
        .v_blank_in     (v_blank_in),
        .pattern_sel    (pattern_sel),
        .frame_count    (frame_count),
        .pattern_active (pattern_active),
        .move_pos       (w_move_pos)
    );

    // ---------------- Stage 1 ----------------
    logic                r1_de;
    logic                r1_h_blank;
    logic                r1_v_blank;
    logic                r1_h_sync;
    logic                r1_v_sync;
    logic [9:0]          r1_h_count;
    logic [2:0]          r1_bar_idx;
    logic                r1_grid_hit;
    logic                r1_checker;
    logic [C_BAR_CW-1:0] r_bar_cnt;

    logic [2:0]          w_bar_idx;
    logic [C_BAR_CW-1:0] w_bar_cnt;
    logic                w_grid_hit;
    logic                w_checker;

    // r1_bar_idx holds the previous dot's bar, so it doubles as counter state.
    always_comb begin
        w_bar_idx = r1_bar_idx;
        w_bar_cnt = r_bar_cnt + C_BAR_CW'(1);
        if (h_count == 10'd0) begin
            w_bar_idx = 3'd0;
            w_bar_cnt = '0;
        end else if (r_bar_cnt == C_BAR_CW'(BAR_W - 1)) begin
            w_bar_cnt = '0;
            if (r1_bar_idx != 3'd7) begin
                w_bar_idx = r1_bar_idx + 3'd1;
            end
        end
    end

    assign w_grid_hit = ((h_count & 10'(GRID_STEP - 1)) == 10'd0)
                     || ((v_count & 10'(GRID_STEP - 1)) == 10'd0)
                     || (h_count == 10'(H_ACTIVE - 1))
                     || (v_count == 10'(V_ACTIVE - 1));

    assign w_checker = h_count[0] ^ v_count[0] ^ frame_count[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r1_de       <= 1'b0;
            r1_h_blank  <= 1'b1;
            r1_v_blank  <= 1'b1;
            r1_h_sync   <= 1'b1;
            r1_v_sync   <= 1'b0;
            r1_h_count  <= 10'd0;
            r1_bar_idx  <= 3'd0;
            r1_grid_hit <= 1'b0;
            r1_checker  <= 1'b0;
            r_bar_cnt   <= '0;
        end else if (ce_pix) begin
            r1_de       <= de_in;
            r1_h_blank  <= h_blank_in;
            r1_v_blank  <= v_blank_in;
            r1_h_sync   <= h_sync_in;
            r1_v_sync   <= v_sync_in;
            r1_h_count  <= h_count;
            r1_bar_idx  <= w_bar_idx;
            r1_grid_hit <= w_grid_hit;
            r1_checker  <= w_checker;
            r_bar_cnt   <= w_bar_cnt;
        end
    end

    // ---------------- Stage 2 ----------------
    rgb_t       w_pix;
    logic [7:0] w_ramp;
    logic       w_move_hit;

    assign w_ramp     = (r1_h_count < 10'd256) ? r1_h_count[7:0] : 8'hFF;
    assign w_move_hit = (r1_h_count >= w_move_pos)
                     && ({1'b0, r1_h_count} < ({1'b0, w_move_pos} + 11'(MOVE_W)));

    always_comb begin
        w_pix = C_BLACK;
        case (pattern_active)
            PAT_BARS:    w_pix = bar_colour(r1_bar_idx);
            PAT_GRID:    w_pix = r1_grid_hit ? C_WHITE : C_BLACK;
            PAT_CHECKER: w_pix = r1_checker ? C_WHITE : C_BLACK;
            PAT_RAMP:    w_pix = {w_ramp, w_ramp, w_ramp};
            PAT_MOVE:    w_pix = w_move_hit ? C_WHITE : C_BLACK;
            default:     w_pix = C_BLACK;
        endcase
        if (!r1_de) begin
            w_pix = C_BLACK;
        end
    end

    rgb_t r_rgb;
    logic r_de;
    logic r_h_blank;
    logic r_v_blank;
    logic r_h_sync;
    logic r_v_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb     <= C_BLACK;
            r_de      <= 1'b0;
            r_h_blank <= 1'b1;
            r_v_blank <= 1'b1;
            r_h_sync  <= 1'b1;
            r_v_sync  <= 1'b0;
        end else if (ce_pix) begin
            r_rgb     <= w_pix;
            r_de      <= r1_de;
            r_h_blank <= r1_h_blank;
            r_v_blank <= r1_v_blank;
            r_h_sync  <= r1_h_sync;
            r_v_sync  <= r1_v_sync;
        end
    end

    assign r           = r_rgb.r;
    assign g           = r_rgb.g;
    assign b           = r_rgb.b;
    assign de_out      = r_de;
    assign h_blank_out = r_h_blank;
    assign v_blank_out = r_v_blank;
    assign h_sync_out  = r_h_sync;
    assign v_sync_out  = r_v_sync;

endmodule

`default_nettype wire

// File: tb/tb_test_pattern_gen.sv
// ============================================================================
// Module      : tb_test_pattern_gen
// Description : Directed self-checking bench for test_pattern_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_test_pattern_gen;

    localparam int H_TOTAL = 330;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce_pix;
    logic       de_in;
    logic       h_blank_in;
    logic       v_blank_in;
    logic       h_sync_in;
    logic       v_sync_in;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic [2:0] pattern_sel;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       de_out;
    logic       h_blank_out;
    logic       v_blank_out;
    logic       h_sync_out;
    logic       v_sync_out;
    logic [2:0] pattern_active;
    logic [7:0] frame_count;

    test_pattern_gen dut (
        .clk            (clk),
        .reset          (reset),
        .ce_pix         (ce_pix),
        .de_in          (de_in),
        .h_blank_in     (h_blank_in),
        .v_blank_in     (v_blank_in),
        .h_sync_in      (h_sync_in),
        .v_sync_in      (v_sync_in),
        .h_count        (h_count),
        .v_count        (v_count),
        .pattern_sel    (pattern_sel),
        .r              (r),
        .g              (g),
        .b              (b),
        .de_out         (de_out),
        .h_blank_out    (h_blank_out),
        .v_blank_out    (v_blank_out),
        .h_sync_out     (h_sync_out),
        .v_sync_out     (v_sync_out),
        .pattern_active (pattern_active),
        .frame_count    (frame_count)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_fc   = 8'd0;
    logic [2:0] exp_pat  = 3'd0;
    int         exp_pos  = 0;

    logic [23:0] line_rgb [0:H_TOTAL-1];
    logic        line_de  [0:H_TOTAL-1];
    logic        line_hs  [0:H_TOTAL-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_pix(input int h, input int v);
        ce_pix     = 1'b1;
        h_count    = 10'(h);
        v_count    = 10'(v);
        h_blank_in = (h >= 320);
        v_blank_in = (v >= 240);
        de_in      = (h < 320) && (v < 240);
        h_sync_in  = !((h >= 322) && (h < 326));
        v_sync_in  = (v >= 242) && (v < 245);
    endtask

    // Captures a full line; index k holds the output for dot k.
    task automatic run_line(input int v);
        for (int i = 0; i < H_TOTAL + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                line_rgb[i-2] = {r, g, b};
                line_de[i-2]  = de_out;
                line_hs[i-2]  = h_sync_out;
            end
            drive_pix((i < H_TOTAL) ? i : H_TOTAL - 1, v);
        end
    endtask

    task automatic new_frame();
        @(negedge clk);
        drive_pix(H_TOTAL - 1, 239);
        @(negedge clk);
        drive_pix(0, 240);
        @(negedge clk);
        exp_fc  = exp_fc + 8'd1;
        exp_pat = pattern_sel;
        exp_pos = (exp_pos + 2 >= 320) ? 0 : exp_pos + 2;
        check("frame_count", 32'(frame_count), 32'(exp_fc));
        check("pattern_active", 32'(pattern_active), 32'(exp_pat));
        drive_pix(1, 240);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, 32'({r, g, b}), 32'h0);
        check({tag, "_timing"},
              32'({de_out, h_blank_out, v_blank_out, h_sync_out, v_sync_out}),
              32'(5'b01110));
        check({tag, "_pat"}, 32'(pattern_active), 32'h0);
        check({tag, "_fc"}, 32'(frame_count), 32'h0);
    endtask

    initial begin
        int first;
        int cnt;
        int exp_cnt;

        reset       = 1'b1;
        pattern_sel = 3'd1;
        drive_pix(10, 10);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        ce_pix = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        // Colour bars and de latency
        pattern_sel = 3'd1;
        new_frame();
        new_frame();
        @(negedge clk); drive_pix(H_TOTAL - 1, 10);
        @(negedge clk); drive_pix(0, 10);
        @(negedge clk); ce_pix = 1'b0;
        check("de_lat_1tick", 32'(de_out), 32'h0);
        @(negedge clk);
        check("de_lat_idle", 32'(de_out), 32'h0);
        drive_pix(1, 10);
        @(negedge clk);
        check("de_lat_2tick", 32'(de_out), 32'h1);

        run_line(10);
        check("bar_d0",   32'(line_rgb[0]),   32'hFFFFFF);
        check("bar_d39",  32'(line_rgb[39]),  32'hFFFFFF);
        check("bar_d40",  32'(line_rgb[40]),  32'hFFFF00);
        check("bar_d79",  32'(line_rgb[79]),  32'hFFFF00);
        check("bar_d80",  32'(line_rgb[80]),  32'h00FFFF);
        check("bar_d200", 32'(line_rgb[200]), 32'hFF0000);
        check("bar_d279", 32'(line_rgb[279]), 32'h0000FF);
        check("bar_d280", 32'(line_rgb[280]), 32'h000000);
        check("bar_d319", 32'(line_rgb[319]), 32'h000000);
        check("bar_de0",   32'(line_de[0]),   32'h1);
        check("bar_de320", 32'(line_de[320]), 32'h0);
        check("hs_321", 32'(line_hs[321]), 32'h1);
        check("hs_322", 32'(line_hs[322]), 32'h0);

        // Grid
        pattern_sel = 3'd2;
        new_frame();
        run_line(5);
        check("grid_0_5",  32'(line_rgb[0]),  32'hFFFFFF);
        check("grid_5_5",  32'(line_rgb[5]),  32'h000000);
        check("grid_16_5", 32'(line_rgb[16]), 32'hFFFFFF);
        run_line(16);
        check("grid_5_16", 32'(line_rgb[5]), 32'hFFFFFF);
        run_line(100);
        check("grid_319_100", 32'(line_rgb[319]), 32'hFFFFFF);
        check("grid_318_100", 32'(line_rgb[318]), 32'h000000);
        run_line(17);
        check("grid_17_17", 32'(line_rgb[17]), 32'h000000);
        run_line(239);
        check("grid_100_239", 32'(line_rgb[100]), 32'hFFFFFF);

        // Unused code renders black while de is active
        pattern_sel = 3'd7;
        new_frame();
        run_line(10);
        check("pat7_d0", 32'(line_rgb[0]), 32'h0);
        check("pat7_de", 32'(line_de[0]), 32'h1);

        // Reset in the middle of an active line
        @(negedge clk);
        drive_pix(50, 60);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset   = 1'b0;
        exp_fc  = 8'd0;
        exp_pat = 3'd0;
        exp_pos = 0;

        // Checkerboard phase follows frame parity
        pattern_sel = 3'd3;
        for (int f = 0; f < 2; f++) begin
            new_frame();
            run_line(0);
            check("chk_0_0", 32'(line_rgb[0]), exp_fc[0] ? 32'hFFFFFF : 32'h0);
            check("chk_1_0", 32'(line_rgb[1]), exp_fc[0] ? 32'h0 : 32'hFFFFFF);
        end

        // Moving bar over a full sweep after a fresh reset
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        exp_fc  = 8'd0;
        exp_pat = 3'd0;
        exp_pos = 0;
        pattern_sel = 3'd5;
        for (int f = 1; f <= 161; f++) begin
            new_frame();
            if (f <= 2 || f >= 159) begin
                run_line(50);
                first = -1;
                cnt   = 0;
                for (int h = 0; h < 320; h++) begin
                    if (line_rgb[h] == 24'hFFFFFF) begin
                        cnt++;
                        if (first < 0) first = h;
                    end
                end
                exp_cnt = (320 - exp_pos < 8) ? 320 - exp_pos : 8;
                check("move_first", 32'(first), 32'(exp_pos));
                check("move_count", 32'(cnt), 32'(exp_cnt));
            end
        end

        // Mid-frame selection change waits for the next boundary
        pattern_sel = 3'd4;
        new_frame();
        pattern_sel = 3'd1;
        run_line(100);
        check("ramp_d0",   32'(line_rgb[0]),   32'h000000);
        check("ramp_d100", 32'(line_rgb[100]), 32'h646464);
        check("ramp_d255", 32'(line_rgb[255]), 32'hFFFFFF);
        check("ramp_d300", 32'(line_rgb[300]), 32'hFFFFFF);
        check("ramp_pat_hold", 32'(pattern_active), 32'h4);
        new_frame();
        run_line(10);
        check("swap_d0",  32'(line_rgb[0]),  32'hFFFFFF);
        check("swap_d40", 32'(line_rgb[40]), 32'hFFFF00);

        // Frame counter wrap 255 -> 0
        do begin
            new_frame();
        end while (exp_fc != 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
